// File: rtl/chan_mux_seq.sv
// -----------------------------------------------------------------------------
// chan_mux_seq
//   N-channel to 1 multiplexer with a single registered output slot.
//   Channels are chosen either by an explicit index (manual mode) or by a
//   round-robin arbiter whose search starts at an internal pointer (auto mode).
//   One transfer per cycle is sustained when downstream keeps out_ready high.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_data    CHANNELS*WIDTH; channel i in bits [i*WIDTH +: WIDTH]
//   in_valid   per-channel data valid
//   in_ready   per-channel accept strobe, one-hot or zero, combinational
//   mode       0 = manual select via sel, 1 = auto round-robin
//   sel        channel index used in manual mode
//   out_data   registered data of the last accepted transfer
//   out_sel    channel index that out_data came from
//   out_valid  output slot holds a transfer
//   out_ready  downstream accept
// -----------------------------------------------------------------------------
module chan_mux_seq #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // Next channel index after idx, wrapping CHANNELS-1 back to 0 (CHANNELS
    // need not be a power of two, so a plain increment is not enough).
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx);
        if ({1'b0, idx} == (SEL_W+1)'(CHANNELS - 1)) begin
            return '0;
        end
        return idx + SEL_W'(1);
    endfunction

    logic [WIDTH-1:0] data_p1;
    logic [SEL_W-1:0] sel_p1;
    logic             vld_p1;
    logic [SEL_W-1:0] ptr;

    logic             slot_free;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic [SEL_W-1:0] cidx;
    int               cand;

    // Stage p0: arbitration on live inputs, combinational accept strobe
    always_comb begin
        slot_free = !vld_p1 || out_ready;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cidx      = '0;
        in_ready  = '0;
        // Gating with rst_n keeps in_ready silent for the whole reset cycle.
        if (rst_n && slot_free) begin
            if (!mode) begin
                // Out-of-range indices (non power-of-two CHANNELS) grant nothing.
                if (({1'b0, sel} < (SEL_W+1)'(CHANNELS)) && in_valid[sel]) begin
                    grant_vld = 1'b1;
                    grant_idx = sel;
                end
            end else begin
                // Lowest offset from ptr wins; the search wraps modulo CHANNELS.
                for (int k = 0; k < CHANNELS; k++) begin
                    cand = int'(ptr) + k;
                    if (cand >= CHANNELS) begin
                        cand = cand - CHANNELS;
                    end
                    cidx = SEL_W'(cand);
                    if (!grant_vld && in_valid[cidx]) begin
                        grant_vld = 1'b1;
                        grant_idx = cidx;
                    end
                end
            end
        end
        if (grant_vld) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign grant_data = in_data[grant_idx*WIDTH +: WIDTH];

    // Stage p1: output slot and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            sel_p1  <= '0;
            ptr     <= '0;
        end else begin
            if (slot_free) begin
                vld_p1 <= grant_vld;
                if (grant_vld) begin
                    data_p1 <= grant_data;
                    sel_p1  <= grant_idx;
                end
            end
            // Manual-mode transfers leave the round-robin position untouched.
            if (grant_vld && mode) begin
                ptr <= wrap_inc(grant_idx);
            end
        end
    end

    assign out_data  = data_p1;
    assign out_sel   = sel_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_chan_mux_seq.sv
// -----------------------------------------------------------------------------
// tb_chan_mux_seq
//   Scoreboard bench for chan_mux_seq (WIDTH=8, CHANNELS=4) plus a small
//   CHANNELS=3 instance for the out-of-range select case. The driver predicts
//   grants from a queue/modulo reference model and pushes expected outputs;
//   a negedge monitor compares whatever the DUT presents.
// -----------------------------------------------------------------------------
module tb_chan_mux_seq;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] sel;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [7:0]  out_data3;
    logic [1:0]  out_sel3;
    logic        out_valid3;
    logic        out_ready3;

    int    tests = 0;
    int    fails = 0;
    item_t sb[$];
    logic  m_vld = 1'b0;
    int    m_ptr = 0;
    logic  clr_pending = 1'b0;
    int    last_grant = -1;

    always #5 clk = ~clk;

    chan_mux_seq #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
    );

    chan_mux_seq #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
        .out_sel(out_sel3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; the model predicts the grant and slot state.
    task automatic step(input logic r, input logic m, input logic [1:0] s,
                        input logic [3:0] v, input logic [31:0] d, input logic ordy);
        int    g;
        logic  free;
        logic [3:0] exp_rdy;
        item_t it;
        @(posedge clk);
        #2;
        if (clr_pending) begin
            sb.delete();
            m_vld = 1'b0;
            m_ptr = 0;
            clr_pending = 1'b0;
        end
        rst_n = r; mode = m; sel = s; in_valid = v; in_data = d; out_ready = ordy;
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_vld));
        g = -1;
        free = !m_vld || ordy;
        if (r && free) begin
            if (!m) begin
                if (v[s]) g = int'(s);
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (g < 0 && v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
                end
            end
        end
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (!r) begin
            clr_pending = 1'b1;
        end else if (g >= 0) begin
            it.data = d[g*8 +: 8];
            it.sel  = 2'(g);
            sb.push_back(it);
            m_vld = 1'b1;
            if (m) m_ptr = (g + 1) % 4;
        end else if (free) begin
            m_vld = 1'b0;
        end
        last_grant = g;
    endtask

    // Monitor: compare the presented item with the scoreboard head; pop on consume.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_empty: out_valid=1 with data %0h, expected no output", out_data);
            end else begin
                chk("out_data", 32'(out_data), 32'(sb[0].data));
                chk("out_sel", 32'(out_sel), 32'(sb[0].sel));
                if (out_ready === 1'b1) void'(sb.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 4'b0; in_data = 32'h0; out_ready = 1'b1;
        mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b0; in_data3 = 24'h0; out_ready3 = 1'b1;

        // Reset state
        step(1'b0, 1'b0, 2'd0, 4'b1111, 32'h0, 1'b1);
        step(1'b0, 1'b1, 2'd0, 4'b1111, 32'h0, 1'b1);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_sel", 32'(out_sel), 32'h0);

        // Manual select, first cycle after reset
        step(1'b1, 1'b0, 2'd2, 4'b0100, 32'h00A5_0000, 1'b1);
        chk("man_in_ready", 32'(in_ready), 32'h4);
        step(1'b1, 1'b0, 2'd2, 4'b0000, 32'h0, 1'b1);
        chk("man_out_data", 32'(out_data), 32'hA5);
        chk("man_out_sel", 32'(out_sel), 32'h2);

        // Auto fairness: 0,1,2,3,0,...
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 2'd0, 4'b1111, 32'h1312_1110, 1'b1);
            if (i > 0) begin
                chk($sformatf("rr_sel_%0d", i), 32'(out_sel), 32'((i - 1) % 4));
                chk($sformatf("rr_data_%0d", i), 32'(out_data), 32'(8'h10 + (i - 1) % 4));
            end
        end
        // ptr is now 2; one more grant on ch2 brings ptr to 3
        step(1'b1, 1'b1, 2'd0, 4'b0100, 32'h1312_1110, 1'b1);
        // Skip and wrap from ptr=3
        step(1'b1, 1'b1, 2'd0, 4'b0011, 32'h1312_1110, 1'b1);
        chk("wrap_grant0", 32'(in_ready), 32'h1);
        step(1'b1, 1'b1, 2'd0, 4'b0011, 32'h1312_1110, 1'b1);
        chk("wrap_grant1", 32'(in_ready), 32'h2);
        step(1'b1, 1'b1, 2'd0, 4'b0011, 32'h1312_1110, 1'b1);
        chk("wrap_grant_from2", 32'(in_ready), 32'h1);

        // Stall: hold 3C for three cycles, then reload on the same edge
        step(1'b1, 1'b0, 2'd1, 4'b0010, 32'h0000_3C00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 2'd0, 4'b1111, 32'h4443_4241, 1'b0);
            chk($sformatf("stall_rdy_%0d", i), 32'(in_ready), 32'h0);
            chk($sformatf("stall_data_%0d", i), 32'(out_data), 32'h3C);
        end
        step(1'b1, 1'b1, 2'd0, 4'b1111, 32'h4443_4241, 1'b1);
        chk("unstall_rdy", 32'(in_ready), 32'h2);
        step(1'b1, 1'b1, 2'd0, 4'b0000, 32'h0, 1'b1);
        chk("unstall_data", 32'(out_data), 32'h42);

        // Reset mid-operation
        step(1'b1, 1'b1, 2'd0, 4'b1111, 32'h5453_5251, 1'b0);
        step(1'b0, 1'b1, 2'd0, 4'b1111, 32'h5453_5251, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'b1111, 32'h5453_5251, 1'b1);
        chk("midrst_data", 32'(out_data), 32'h0);
        chk("midrst_sel", 32'(out_sel), 32'h0);
        chk("midrst_first_grant", 32'(in_ready), 32'h1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0));
        end

        // Drain and idle
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd0, 4'b0000, 32'h0, 1'b1);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        // CHANNELS=3 instance: out-of-range select
        @(posedge clk); #2;
        mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b111; in_data3 = 24'h66_55_77; out_ready3 = 1'b1;
        #1;
        chk("c3_in_ready_sel0", 32'(in_ready3), 32'h1);
        @(posedge clk); #2;
        sel3 = 2'd3;
        #1;
        chk("c3_in_ready_sel3", 32'(in_ready3), 32'h0);
        chk("c3_out_valid", 32'(out_valid3), 32'h1);
        chk("c3_out_data", 32'(out_data3), 32'h77);
        @(posedge clk); #3;
        chk("c3_in_ready_sel3_b", 32'(in_ready3), 32'h0);
        chk("c3_out_valid_fall", 32'(out_valid3), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
